// File: rtl/regfile_dump_reader.sv
// Walks a combinational regfile read port from register 0 to NUM_REGS-1.
// Each captured (addr, data) pair is streamed out over a valid/ready interface.
module regfile_dump_reader #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StCapture, StHold, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;

    assign accept = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                raddr_d = '0;
                if (start) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                out_data_d  = rdata;
                out_addr_d  = raddr_q;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    if (out_addr_q == LastAddr) begin
                        state_d = StDone;
                    end else begin
                        // Advance only on acceptance, so no register is read twice.
                        raddr_d = raddr_q + ADDR_W'(1);
                        state_d = StCapture;
                    end
                end
            end
            StDone: begin
                raddr_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides every state, including a start seen in idle.
        if (abort) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            raddr_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            raddr_q     <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign raddr     = raddr_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a regfile array on the read port, with the expected beat
// stream derived from snapshot-at-start plus the rule that writes above the in-flight beat land.
module tb_regfile_dump_reader;

    localparam int DataW   = 32;
    localparam int AddrW   = 5;
    localparam int NumRegs = 32;
    localparam int Budget  = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [AddrW-1:0] raddr;
    logic [DataW-1:0] rdata;
    logic             out_valid;
    logic             out_ready;
    logic [AddrW-1:0] out_addr;
    logic [DataW-1:0] out_data;
    logic             busy;
    logic             done;

    logic [DataW-1:0] regs     [NumRegs];
    logic [DataW-1:0] exp_data [NumRegs];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rdata = regs[raddr];

    regfile_dump_reader #(
        .DATA_W  (DataW),
        .ADDR_W  (AddrW),
        .NUM_REGS(NumRegs)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .raddr    (raddr),
        .rdata    (rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit random_fill);
        for (int i = 0; i < NumRegs; i++) begin
            regs[i] = random_fill ? DataW'($urandom()) : DataW'(i) * 32'h01010101;
        end
        regs[0] = '0;
    endtask

    // A write reaches the dump only if that register has not been captured yet.
    task automatic write_reg(input int r, input logic [DataW-1:0] v, input int cur);
        regs[r] = v;
        if (r > cur) exp_data[r] = v;
    endtask

    // mode: 0 ready always, 1 random ready, 2 stall 5 cycles on addr 3
    // wmode: 0 no writes, 1 directed writes at beat 2, 2 random writes
    task automatic run_dump(input int mode, input int wmode, input int abort_beat,
                            input int rst_beat, input int restart_beat, output int done_cyc);
        int               cyc;
        int               beats;
        int               dones;
        int               last_acc;
        int               exp_valid_cyc;
        int               stall;
        bit               seen;
        bit               stop;
        bit               cut;
        logic [AddrW-1:0] h_addr;
        logic [DataW-1:0] h_data;

        for (int i = 0; i < NumRegs; i++) exp_data[i] = regs[i];
        start = 1'b1;
        tick();
        cyc = 1; beats = 0; dones = 0; last_acc = -10; exp_valid_cyc = 2; stall = 0;
        seen = 1'b0; stop = 1'b0; cut = 1'b0; done_cyc = -1;
        h_addr = '0; h_data = '0;

        while (!stop && cyc < Budget) begin
            start = 1'b0;
            abort = 1'b0;
            if (beats == NumRegs && cyc == last_acc + 2) begin
                check("end_busy", 64'(busy), 64'(0));
                check("end_valid", 64'(out_valid), 64'(0));
                check("end_raddr", 64'(raddr), 64'(0));
                stop = 1'b1;
            end else begin
                check("busy", 64'(busy), 64'(1));
                check("done", 64'(done), 64'(beats == NumRegs && cyc == last_acc + 1));
                check("raddr", 64'(raddr), 64'((beats < NumRegs) ? beats : NumRegs - 1));
                if (done) begin
                    dones++;
                    done_cyc = cyc;
                end
                out_ready = 1'($urandom_range(0, 1));
                if (!out_valid && seen) check("valid_held", 64'(out_valid), 64'(1));
                if (out_valid) begin
                    if (!seen) begin
                        check("beat_cycle", 64'(cyc), 64'(exp_valid_cyc));
                        check("beat_addr", 64'(out_addr), 64'(beats));
                        check("beat_data", 64'(out_data), 64'(exp_data[beats % NumRegs]));
                        h_addr = out_addr;
                        h_data = out_data;
                        seen   = 1'b1;
                        if (wmode == 1 && beats == 2) begin
                            write_reg(5, 32'hDEADBEEF, beats);
                            write_reg(1, 32'h12345678, beats);
                        end
                    end else begin
                        check("hold_addr", 64'(out_addr), 64'(h_addr));
                        check("hold_data", 64'(out_data), 64'(h_data));
                    end
                    if (wmode == 2 && $urandom_range(0, 3) == 0) begin
                        write_reg(int'($urandom_range(1, NumRegs - 1)), DataW'($urandom()),
                                  beats);
                    end
                    if (mode == 0) begin
                        out_ready = 1'b1;
                    end else if (mode == 2) begin
                        out_ready = !(out_addr == 3 && stall < 5);
                        if (!out_ready) stall++;
                    end
                    if (beats == restart_beat) start = 1'b1;
                    if (beats == abort_beat) begin
                        abort     = 1'b1;
                        out_ready = 1'b1;
                        cut       = 1'b1;
                    end
                    if (beats == rst_beat) begin
                        rst = 1'b1;
                        cut = 1'b1;
                    end
                    if (out_ready && !cut) begin
                        last_acc      = cyc;
                        beats++;
                        seen          = 1'b0;
                        exp_valid_cyc = cyc + 2;
                    end
                end
                tick();
                cyc++;
                if (cut) begin
                    check("cut_valid", 64'(out_valid), 64'(0));
                    check("cut_busy", 64'(busy), 64'(0));
                    check("cut_raddr", 64'(raddr), 64'(0));
                    check("cut_done", 64'(done), 64'(0));
                    if (rst) begin
                        check("rst_out_addr", 64'(out_addr), 64'(0));
                        check("rst_out_data", 64'(out_data), 64'(0));
                    end
                    rst   = 1'b0;
                    abort = 1'b0;
                    stop  = 1'b1;
                end
            end
        end
        check("run_complete", 64'(stop), 64'(1));
        check("done_count", 64'(dones), 64'((abort_beat < 0 && rst_beat < 0) ? 1 : 0));
    endtask

    initial begin
        int dc;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        preload(1'b0);
        repeat (3) tick();
        check("rst_raddr", 64'(raddr), 64'(0));
        check("rst_out_addr", 64'(out_addr), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'(0));

        // Full dump with ready held high.
        run_dump(0, 0, -1, -1, -1, dc);
        check("t1_done_cycle", 64'(dc), 64'(65));

        // Five-cycle back-pressure on addr 3.
        run_dump(2, 0, -1, -1, -1, dc);
        check("t2_done_cycle", 64'(dc), 64'(70));

        // Abort at beat 10, then a fresh dump from addr 0.
        run_dump(0, 0, 10, -1, -1, dc);
        run_dump(0, 0, -1, -1, -1, dc);
        check("t3_redump_done_cycle", 64'(dc), 64'(65));

        // Start while busy is ignored.
        run_dump(0, 0, -1, -1, 7, dc);
        check("t4_done_cycle", 64'(dc), 64'(65));

        // Writes before and after capture.
        preload(1'b0);
        run_dump(0, 1, -1, -1, -1, dc);
        check("t5_done_cycle", 64'(dc), 64'(65));

        // Start together with abort in idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'(0));
        tick();
        check("start_abort_busy2", 64'(busy), 64'(0));

        // Random data, random ready, random writes.
        for (int k = 0; k < 4; k++) begin
            preload(1'b1);
            run_dump(1, 2, -1, -1, -1, dc);
        end

        // Reset mid-dump, then reset held with start.
        preload(1'b0);
        run_dump(1, 0, -1, 20, -1, dc);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        check("rst_start_busy", 64'(busy), 64'(0));
        check("rst_start_valid", 64'(out_valid), 64'(0));
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy), 64'(0));
        run_dump(0, 0, -1, -1, -1, dc);
        check("post_rst_done_cycle", 64'(dc), 64'(65));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
